// File: rtl/alu_logic_norm_seq_pkg.sv
// rtl/alu_logic_norm_seq_pkg.sv - shared types and width helper for the left normalizer
package alu_logic_norm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } norm_state_t;

    // Shift amounts must represent 0..N inclusive, hence one bit beyond clog2.
    function automatic int sw_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/alu_logic_norm_seq_if.sv
// rtl/alu_logic_norm_seq_if.sv - request/result handshake bundle for the left normalizer
interface alu_logic_norm_seq_if
    import alu_logic_norm_seq_pkg::*;
#(
    parameter int N  = 32,
    parameter int SW = sw_width(N)
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a;
    logic          in_use_clz;
    logic [SW-1:0] in_shamt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_y;
    logic [SW-1:0] out_shamt;
    logic          out_all_zero;

    modport master (
        output in_valid, in_a, in_use_clz, in_shamt, out_ready,
        input  in_ready, out_valid, out_y, out_shamt, out_all_zero
    );

    modport slave (
        input  in_valid, in_a, in_use_clz, in_shamt, out_ready,
        output in_ready, out_valid, out_y, out_shamt, out_all_zero
    );
endinterface

// File: rtl/alu_logic_norm_seq_clz.sv
// rtl/alu_logic_norm_seq_clz.sv - combinational leading-zero counter (alu_logic_clz)
module alu_logic_clz
    import alu_logic_norm_seq_pkg::*;
#(
    parameter int N  = 32,
    parameter int SW = sw_width(N)
) (
    input  logic [N-1:0]  i_a,
    output logic [SW-1:0] o_y,
    output logic          o_all_zero
);
    logic [SW-1:0] w_cnt;

    // Scanning upward lets the highest set bit overwrite earlier hits.
    always_comb begin
        w_cnt = SW'(N);
        for (int i = 0; i < N; i++) begin
            if (i_a[i]) begin
                w_cnt = SW'(N - 1 - i);
            end
        end
    end

    assign o_y        = w_cnt;
    assign o_all_zero = (i_a == '0);
endmodule

// File: rtl/alu_logic_norm_seq.sv
// rtl/alu_logic_norm_seq.sv - multi-cycle left normalizer, up to STEP bits of shift per cycle
module alu_logic_norm_seq
    import alu_logic_norm_seq_pkg::*;
#(
    parameter int N    = 32,
    parameter int STEP = 4,
    parameter int SW   = sw_width(N)
) (
    input  logic               clk,
    input  logic               reset,
    alu_logic_norm_seq_if.slave bus
);
    localparam logic [SW-1:0] LP_N    = SW'(N);
    localparam logic [SW-1:0] LP_STEP = SW'(STEP);

    norm_state_t   r_state;
    logic [N-1:0]  r_data;
    logic [SW-1:0] r_rem;
    logic [SW-1:0] r_shamt;
    logic          r_all_zero;

    logic [SW-1:0] w_clz_y;
    logic          w_clz_zero;
    logic [SW-1:0] w_sel;
    logic [SW-1:0] w_clamped;
    logic [SW-1:0] w_step;

    alu_logic_clz #(.N(N), .SW(SW)) u_clz (
        .i_a        (bus.in_a),
        .o_y        (w_clz_y),
        .o_all_zero (w_clz_zero)
    );

    assign w_sel     = bus.in_use_clz ? w_clz_y : bus.in_shamt;
    assign w_clamped = (w_sel > LP_N) ? LP_N : w_sel;
    assign w_step    = (r_rem > LP_STEP) ? LP_STEP : r_rem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_data     <= '0;
            r_rem      <= '0;
            r_shamt    <= '0;
            r_all_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_data     <= bus.in_a;
                        r_rem      <= w_clamped;
                        r_shamt    <= w_clamped;
                        r_all_zero <= w_clz_zero;
                        r_state    <= (w_clamped == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    r_data <= r_data << w_step;
                    r_rem  <= r_rem - w_step;
                    if (r_rem == w_step) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready     = (r_state == IDLE);
    assign bus.out_valid    = (r_state == DONE);
    assign bus.out_y        = r_data;
    assign bus.out_shamt    = r_shamt;
    assign bus.out_all_zero = r_all_zero;
endmodule

// File: tb/tb_alu_logic_norm_seq.sv
// tb/tb_alu_logic_norm_seq.sv - directed self-checking bench for alu_logic_norm_seq
module tb_alu_logic_norm_seq;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    alu_logic_norm_seq_if #(.N(32), .SW(6)) bus ();

    alu_logic_norm_seq #(.N(32), .STEP(4), .SW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges counted from the edge that accepts the request until out_valid is seen.
    task automatic do_req(input logic [31:0] a, input logic use_clz, input logic [5:0] shamt,
                          output int edges);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_a       = a;
        bus.in_use_clz = use_clz;
        bus.in_shamt   = shamt;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.in_a       = 32'hDEAD_BEEF;
        bus.in_use_clz = ~use_clz;
        bus.in_shamt   = 6'd7;
        edges = 1;
        while (!bus.out_valid && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic do_handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_result(input string name, input int edges, input int exp_edges,
                                input logic [31:0] exp_y, input logic [5:0] exp_sh,
                                input logic exp_az);
        n_checks++;
        if (edges !== exp_edges) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d edges want %0d", name, edges, exp_edges);
        end
        n_checks++;
        if (bus.out_y !== exp_y) begin
            n_fail++;
            $display("FAIL %s_y: got %h want %h", name, bus.out_y, exp_y);
        end
        n_checks++;
        if (bus.out_shamt !== exp_sh) begin
            n_fail++;
            $display("FAIL %s_shamt: got %0d want %0d", name, bus.out_shamt, exp_sh);
        end
        n_checks++;
        if (bus.out_all_zero !== exp_az) begin
            n_fail++;
            $display("FAIL %s_all_zero: got %b want %b", name, bus.out_all_zero, exp_az);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_handshake: got in_ready=%b out_valid=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
        n_checks++;
        if ({bus.out_y, bus.out_shamt, bus.out_all_zero} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got y=%h sh=%0d az=%b want 0 0 0",
                     bus.out_y, bus.out_shamt, bus.out_all_zero);
        end
    endtask

    task automatic test_count_path();
        int e;
        do_req(32'h0000_1234, 1'b1, 6'd0, e);
        check_result("count", e, 6, 32'h91A0_0000, 6'd19, 1'b0);
        do_handshake();
    endtask

    task automatic test_normalized();
        int e;
        do_req(32'h8000_0001, 1'b1, 6'd0, e);
        check_result("normalized", e, 1, 32'h8000_0001, 6'd0, 1'b0);
        do_handshake();
    endtask

    task automatic test_zero();
        int e;
        do_req(32'h0000_0000, 1'b1, 6'd0, e);
        check_result("zero", e, 9, 32'h0000_0000, 6'd32, 1'b1);
        do_handshake();
    endtask

    task automatic test_external();
        int e;
        do_req(32'hFFFF_FFFF, 1'b0, 6'd5, e);
        check_result("ext5", e, 3, 32'hFFFF_FFE0, 6'd5, 1'b0);
        do_handshake();
        do_req(32'hFFFF_FFFF, 1'b0, 6'd40, e);
        check_result("ext40", e, 9, 32'h0000_0000, 6'd32, 1'b0);
        do_handshake();
        do_req(32'h0000_1234, 1'b0, 6'd3, e);
        check_result("partial", e, 2, 32'h0000_91A0, 6'd3, 1'b0);
        do_handshake();
    endtask

    task automatic test_backpressure();
        int e;
        do_req(32'h00F0_0000, 1'b1, 6'd0, e);
        check_result("bp", e, 3, 32'hF000_0000, 6'd8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_y, bus.out_shamt} !== {2'b10, 32'hF000_0000, 6'd8}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b r=%b y=%h sh=%0d want 1 0 f0000000 8",
                         i, bus.out_valid, bus.in_ready, bus.out_y, bus.out_shamt);
            end
        end
        do_handshake();
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        do_req(32'h0000_0001, 1'b1, 6'd0, e);
        check_result("b2b_a", e, 9, 32'h8000_0000, 6'd31, 1'b0);
        do_handshake();
        do_req(32'h4000_0000, 1'b0, 6'd1, e);
        check_result("b2b_b", e, 2, 32'h8000_0000, 6'd1, 1'b0);
        do_handshake();
    endtask

    task automatic test_reset_mid_shift();
        int e;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_a       = 32'h0000_1234;
        bus.in_use_clz = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_y, bus.out_shamt, bus.out_all_zero}
            !== {2'b10, 39'd0}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got r=%b v=%b y=%h sh=%0d az=%b want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_y, bus.out_shamt, bus.out_all_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL midreset_release: got in_ready=%b out_valid=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
        do_req(32'h0000_1234, 1'b1, 6'd0, e);
        check_result("after_reset", e, 6, 32'h91A0_0000, 6'd19, 1'b0);
        do_handshake();
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_use_clz = 1'b0;
        bus.in_shamt   = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_count_path();
        test_normalized();
        test_zero();
        test_external();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
